// File: rtl/sram_block_mover.sv
// sram_block_mover: moves 64-bit DES blocks between the byte-wide sram and the DES datapath
module sram_block_mover #(
    parameter logic [15:0] BASE_ADDR = 16'h0001,
    parameter int          NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   load_start,
    input  logic                   store_start,
    input  logic [8*NUM_BYTES-1:0] block_in,
    output logic [8*NUM_BYTES-1:0] block_out,
    output logic                   block_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_read_enable,
    output logic                   sram_write_enable,
    output logic [15:0]            sram_address,
    output logic [7:0]             sram_write_data,
    input  logic [7:0]             sram_read_data
);
    localparam int BW = 8 * NUM_BYTES;
    localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2, DONE = 2'd3;
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [BW-1:0] sreg;
    // Sequencer: one sram byte per cycle, load wins over store, starts ignored while busy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state             <= IDLE;
            idx               <= '0;
            sreg              <= '0;
            block_out         <= '0;
            block_valid       <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            sram_read_enable  <= 1'b0;
            sram_write_enable <= 1'b0;
            sram_address      <= '0;
            sram_write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state            <= LOAD;
                        idx              <= '0;
                        sram_address     <= BASE_ADDR;
                        sram_read_enable <= 1'b1;
                        block_valid      <= 1'b0;
                        busy             <= 1'b1;
                    end else if (store_start) begin
                        state             <= STORE;
                        idx               <= '0;
                        sreg              <= block_in;
                        sram_address      <= BASE_ADDR;
                        sram_write_enable <= 1'b1;
                        sram_write_data   <= block_in[7:0];
                        busy              <= 1'b1;
                    end
                end
                LOAD: begin
                    block_out[8*idx +: 8] <= sram_read_data;
                    idx                   <= idx + 1'b1;
                    sram_address          <= sram_address + 16'd1;
                    if (idx == LAST) begin
                        state            <= DONE;
                        sram_read_enable <= 1'b0;
                        sram_address     <= '0;
                        block_valid      <= 1'b1;
                        done             <= 1'b1;
                    end
                end
                STORE: begin
                    idx             <= idx + 1'b1;
                    sram_address    <= sram_address + 16'd1;
                    sram_write_data <= sreg[15:8];
                    sreg            <= sreg >> 8;
                    if (idx == LAST) begin
                        state             <= DONE;
                        sram_write_enable <= 1'b0;
                        sram_address      <= '0;
                        sram_write_data   <= '0;
                        done              <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_block_mover.sv
// tb_sram_block_mover: randomized check of sram_block_mover against a byte-array sram model
module tb_sram_block_mover;
    localparam logic [15:0] BASE = 16'h0001;
    logic        clk = 1'b0, n_rst = 1'b0, load_start = 1'b0, store_start = 1'b0;
    logic [63:0] block_in = '0, block_out;
    logic        block_valid, busy, done, sram_read_enable, sram_write_enable;
    logic [15:0] sram_address;
    logic [7:0]  sram_write_data, sram_read_data;
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        exp_valid = 1'b0;
    int          total = 0, bad = 0;

    sram_block_mover dut (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .store_start(store_start),
        .block_in(block_in), .block_out(block_out), .block_valid(block_valid),
        .busy(busy), .done(done), .sram_read_enable(sram_read_enable),
        .sram_write_enable(sram_write_enable), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;
    assign sram_read_data = mem[sram_address];
    always @(posedge clk) if (sram_write_enable) mem[sram_address] <= sram_write_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) chk("excl", {63'd0, sram_read_enable & sram_write_enable}, 64'd0);

    function automatic logic [63:0] ref_block();
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[8*i +: 8] = ref_mem[BASE + 16'(i)];
        return b;
    endfunction

    task automatic do_store(input logic [63:0] blk, input int rst_at);
        @(negedge clk);
        block_in = blk;
        store_start = 1'b1;
        @(negedge clk);
        store_start = 1'b0;
        block_in = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            if (i == rst_at) begin
                n_rst = 1'b0;
                #1;
                exp_valid = 1'b0;
                chk("rst_we", {63'd0, sram_write_enable}, 64'd0);
                chk("rst_re", {63'd0, sram_read_enable}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_valid", {63'd0, block_valid}, 64'd0);
                chk("rst_out", block_out, 64'd0);
                chk("rst_addr", {48'd0, sram_address}, 64'd0);
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            chk("st_we", {63'd0, sram_write_enable}, 64'd1);
            chk("st_re", {63'd0, sram_read_enable}, 64'd0);
            chk("st_addr", {48'd0, sram_address}, {48'd0, BASE + 16'(i)});
            chk("st_data", {56'd0, sram_write_data}, {56'd0, blk[8*i +: 8]});
            chk("st_done", {63'd0, done}, 64'd0);
            chk("st_busy", {63'd0, busy}, 64'd1);
            ref_mem[BASE + 16'(i)] = blk[8*i +: 8];
            @(negedge clk);
        end
        chk("st_fin_done", {63'd0, done}, 64'd1);
        chk("st_fin_busy", {63'd0, busy}, 64'd1);
        chk("st_fin_we", {63'd0, sram_write_enable}, 64'd0);
        chk("st_fin_addr", {48'd0, sram_address}, 64'd0);
        chk("st_fin_data", {56'd0, sram_write_data}, 64'd0);
        chk("st_fin_valid", {63'd0, block_valid}, {63'd0, exp_valid});
        @(negedge clk);
        chk("st_idle_done", {63'd0, done}, 64'd0);
        chk("st_idle_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 8; i++)
            chk("st_mem", {56'd0, mem[BASE + 16'(i)]}, {56'd0, ref_mem[BASE + 16'(i)]});
    endtask

    task automatic do_load(input bit both, input bit poke);
        @(negedge clk);
        load_start = 1'b1;
        store_start = both;
        block_in = {$urandom, $urandom};
        @(negedge clk);
        load_start = 1'b0;
        store_start = 1'b0;
        exp_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            store_start = poke && (i == 3);
            chk("ld_re", {63'd0, sram_read_enable}, 64'd1);
            chk("ld_we", {63'd0, sram_write_enable}, 64'd0);
            chk("ld_addr", {48'd0, sram_address}, {48'd0, BASE + 16'(i)});
            chk("ld_valid", {63'd0, block_valid}, 64'd0);
            chk("ld_done", {63'd0, done}, 64'd0);
            chk("ld_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        store_start = 1'b0;
        exp_valid = 1'b1;
        chk("ld_fin_done", {63'd0, done}, 64'd1);
        chk("ld_fin_busy", {63'd0, busy}, 64'd1);
        chk("ld_fin_re", {63'd0, sram_read_enable}, 64'd0);
        chk("ld_fin_addr", {48'd0, sram_address}, 64'd0);
        chk("ld_fin_valid", {63'd0, block_valid}, 64'd1);
        chk("ld_block", block_out, ref_block());
        @(negedge clk);
        chk("ld_idle_done", {63'd0, done}, 64'd0);
        chk("ld_idle_busy", {63'd0, busy}, 64'd0);
        chk("ld_idle_we", {63'd0, sram_write_enable}, 64'd0);
        chk("ld_hold", block_out, ref_block());
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_block", block_out, 64'd0);
        chk("rst_ctl", {32'd0, block_valid, busy, done, sram_read_enable, sram_write_enable,
                        sram_address, sram_write_data}, 64'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_block", block_out, 64'd0);
            chk("idle_ctl", {32'd0, block_valid, busy, done, sram_read_enable, sram_write_enable,
                             sram_address, sram_write_data}, 64'd0);
        end
        do_store(64'h0123456789ABCDEF, 8);
        do_load(1'b0, 1'b0);
        chk("known_block", block_out, 64'h0123456789ABCDEF);
        do_store({$urandom, $urandom}, 8);
        do_load(1'b1, 1'b0);
        do_store({$urandom, $urandom}, 8);
        do_load(1'b0, 1'b1);
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 2))
                0: do_store({$urandom, $urandom}, 8);
                1: do_load(1'b0, 1'b0);
                default: do_load(1'b1, ($urandom_range(0, 1) == 1));
            endcase
        end
        do_load(1'b0, 1'b0);
        do_store({$urandom, $urandom}, 4);
        do_load(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
